// File: rtl/input_vc_buffer_credit_return.sv
// Receiver-side per-VC flit buffers with credit return
// and per-VC packet framing / protocol error tracking.
module input_vc_buffer_credit_return #(
  parameter int DW        = 32,
  parameter int V         = 4,
  parameter int BUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_dat,
  input  logic [V-1:0]    rd_en,
  output logic [V-1:0]    out_valid,
  output logic [V*DW-1:0] out_dat,
  output logic [V-1:0]    out_is_head,
  output logic [V-1:0]    pkt_active,
  output logic [V-1:0]    credit_update,
  output logic [V-1:0]    ovf_err,
  output logic [V-1:0]    udf_err,
  output logic [V-1:0]    seq_err
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam logic [1:0] HEAD   = 2'b00;
  localparam logic [1:0] BODY   = 2'b01;
  localparam logic [1:0] TAIL   = 2'b10;
  localparam logic [1:0] SINGLE = 2'b11;

  logic [1:0] wvc;
  logic [1:0] ftype;

  assign wvc   = in_dat[DW-1:DW-2];
  assign ftype = in_dat[DW-3:DW-4];

  for (genvar v = 0; v < V; v++) begin : g_vc
    logic [DW-1:0] mem [BUF_DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic [0:0]    st;
    logic          cr;
    logic          ovf;
    logic          udf;
    logic          seq;
    logic          hit;
    logic          empty;
    logic          full;
    logic          rok;
    logic          wok;
    logic [1:0]    front_t;

    assign hit   = in_valid && (wvc == 2'(v));
    assign empty = (cnt == '0);
    assign full  = (cnt == FULL);
    assign rok   = rd_en[v] && !empty;
    // a full VC still accepts when the same cycle frees a slot
    assign wok   = hit && (!full || rok);

    always_ff @(posedge clk) begin
      if (wok) mem[wp] <= in_dat;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        st  <= IDLE;
        cr  <= 1'b0;
        ovf <= 1'b0;
        udf <= 1'b0;
        seq <= 1'b0;
      end else begin
        cr <= rok;
        if (wok) wp <= wp + AW'(1);
        if (rok) rp <= rp + AW'(1);
        if (wok && !rok) cnt <= cnt + CW'(1);
        else if (rok && !wok) cnt <= cnt - CW'(1);
        if (hit && full && !rok) ovf <= 1'b1;
        if (rd_en[v] && empty) udf <= 1'b1;
        if (hit) begin
          unique case (1'b1)
            (st == IDLE): begin
              if (ftype == HEAD) st <= ACTIVE;
              else if (ftype == BODY || ftype == TAIL) seq <= 1'b1;
            end
            default: begin
              if (ftype == TAIL) st <= IDLE;
              else if (ftype != BODY) seq <= 1'b1;
            end
          endcase
        end
      end
    end

    assign front_t = mem[rp][DW-3:DW-4];

    assign out_valid[v]          = !empty;
    assign out_dat[v*DW +: DW]   = mem[rp];
    assign out_is_head[v]        = !empty &&
                                   (front_t == HEAD || front_t == SINGLE);
    assign pkt_active[v]         = (st == ACTIVE);
    assign credit_update[v]      = cr;
    assign ovf_err[v]            = ovf;
    assign udf_err[v]            = udf;
    assign seq_err[v]            = seq;
  end

endmodule

// File: doc/input_vc_buffer_credit_return.md
Name: input_vc_buffer_credit_return

Overview:
- Downstream (receiver) end of the credit-based link: the per-input-port VC buffer bank that stores incoming flits per VC.
- Presents each VC's front flit to the route/VC/switch allocation stages.
- Returns one credit-update pulse per dequeued flit to the upstream output VC controllers.
- Tracks per-VC packet framing and flags protocol violations (credit overrun, underflow, framing).

Parameters:
- DW, 32, flit width in bits; DW-1:DW-2 = VC id, DW-3:DW-4 = flit type.
- V, 4, number of VCs per port; VC id field is 2 bits, so V <= 4.
- BUF_DEPTH, 4, flits per VC FIFO; power of two, >= 2; matches the upstream credit count.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  flit present on link this cycle
- in_dat  in  DW  link flit
- rd_en  in  V  per-VC dequeue strobe from switch traversal, at most one bit set
- out_valid  out  V  VC FIFO non-empty
- out_dat  out  V*DW  front flit of each VC; VC v occupies bits [v*DW +: DW]
- out_is_head  out  V  front flit type is HEAD or SINGLE, gated by out_valid
- pkt_active  out  V  HEAD enqueued, TAIL not yet enqueued
- credit_update  out  V  one-cycle credit pulse per dequeued flit
- ovf_err  out  V  sticky: write to full VC
- udf_err  out  V  sticky: rd_en to empty VC
- seq_err  out  V  sticky: framing violation

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at posedge): all FIFOs empty, pointers and counts 0, out_valid=0, out_is_head=0, pkt_active=0, credit_update=0, all err=0.
  - Applies mid-packet or mid-transfer; in-flight flits are discarded.
  - No credits are emitted for discarded flits; upstream is reset concurrently.
- Flit type encoding: 00 HEAD, 01 BODY, 10 TAIL, 11 SINGLE (head+tail).
- Enqueue: in_valid=1 writes in_dat into the FIFO selected by v = in_dat[DW-1:DW-2].
  - The flit is visible on out_valid/out_dat the next cycle; there is no same-cycle bypass.
  - A VC id >= V is dropped, with no error flag and no state change.
- Dequeue: rd_en[v]=1 with out_valid[v]=1 advances the read pointer of VC v at posedge.
  - out_dat is combinational from the FIFO head (first-word fall-through).
- Credit return: each accepted dequeue on VC v drives credit_update[v]=1 for exactly one cycle, the cycle after rd_en[v].
  - Back-to-back dequeues produce back-to-back pulses.
  - Dropped writes and ignored reads never produce credits.
- Occupancy: per-VC count has width clog2(BUF_DEPTH)+1, range 0..BUF_DEPTH. Pointers have width clog2(BUF_DEPTH) and wrap modulo BUF_DEPTH.
- Full write: if count==BUF_DEPTH and no dequeue on the same VC this cycle, the flit is dropped and ovf_err[v] is set.
- Full write with a same-cycle dequeue on that VC: both happen, the count stays BUF_DEPTH, and no error is flagged.
- Empty read: rd_en[v] with count==0 is ignored and sets udf_err[v]. A same-cycle write to an empty VC is not readable that cycle and is still an underflow.
- Simultaneous read and write on the same VC (non-empty): count unchanged, both pointers advance.
- Packet framing FSM per VC, updated on accepted or dropped enqueue (states IDLE, ACTIVE):
  - IDLE + HEAD -> ACTIVE
  - IDLE + SINGLE -> IDLE
  - IDLE + BODY/TAIL -> IDLE, seq_err set
  - ACTIVE + BODY -> ACTIVE
  - ACTIVE + TAIL -> IDLE
  - ACTIVE + HEAD/SINGLE -> ACTIVE, seq_err set; a new packet is assumed to start
- pkt_active[v] = (state==ACTIVE). Framing-error flits are still stored if space exists.
- Error flags clear only on rst.
- Multiple rd_en bits set in one cycle: each VC is serviced independently. This is not a violation for this block.

Test Plan:
- Reset and idle: assert rst for 2 cycles -> all outputs 0; hold in_valid=0 for 10 cycles -> no credit_update pulses.
- Single flit: SINGLE flit with VC id 2 at cycle t -> out_valid=0100 and out_is_head[2]=1 at t+1; rd_en=0100 at t+1 -> credit_update=0100 at t+2 only, out_valid=0 at t+2.
- Fill/overflow on VC 1:
  - HEAD, BODY, BODY, BODY -> count 4, pkt_active[1]=1.
  - A 5th BODY -> dropped, ovf_err[1]=1.
  - Draining 4 -> exactly 4 credit pulses in FIFO order with the original data.
- Full with concurrent dequeue: VC 0 full, TAIL written with rd_en[0]=1 the same cycle -> no ovf_err, count stays 4, the TAIL is the last flit read, pkt_active[0] falls after the TAIL write.
- Interleaved VCs and errors:
  - Alternate VC 0/3 flits -> per-VC ordering preserved.
  - BODY to idle VC 3 -> seq_err[3]=1.
  - rd_en[2] on empty VC 2 -> udf_err[2]=1, no credit.
- Reset mid-packet: 3 flits buffered in VC 1, rst for 1 cycle -> out_valid=0, pkt_active=0, no credit pulses after reset; next HEAD is accepted normally.
